// File: rtl/bcd_seq_ctrl_if.sv
// rtl/bcd_seq_ctrl_if.sv - start/word request and status/result bundle for bcd_seq_ctrl
interface bcd_seq_ctrl_if #(
  parameter int NDIG = 4
);
  logic                in_start;
  logic [4*NDIG-1:0]   in_data;
  logic                out_busy;
  logic                out_done;
  logic                out_err;
  logic [4*NDIG-1:0]   out_result;

  modport master (
    output in_start, in_data,
    input  out_busy, out_done, out_err, out_result
  );

  modport slave (
    input  in_start, in_data,
    output out_busy, out_done, out_err, out_result
  );
endinterface

// File: rtl/bcd_seq_ctrl.sv
// rtl/bcd_seq_ctrl.sv - walks a packed BCD word through an external digit converter, LSD first
// Each digit is held SETTLE cycles, then the converter output is captured; non-BCD digits abort.
module bcd_seq_ctrl #(
  parameter int NDIG   = 4,
  parameter int SETTLE = 1
) (
  input  logic         in_clk,
  input  logic         in_rst,
  bcd_seq_ctrl_if.slave bus,
  output logic         out_A,
  output logic         out_B,
  output logic         out_C,
  output logic         out_D,
  input  logic         in_W,
  input  logic         in_X,
  input  logic         in_Y,
  input  logic         in_Z
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*NDIG-1:0]   word_q, word_d;
  logic [4*NDIG-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [3:0]          digit;
  logic [3:0]          drive;
  logic [3:0]          conv;

  assign digit = word_q[{idx_q, 2'b00} +: 4];
  assign conv  = {in_W, in_X, in_Y, in_Z};

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    result_d = result_q;
    err_d    = err_q;
    drive    = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_start) begin
          word_d   = bus.in_data;
          result_d = '0;
          err_d    = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        drive = digit;
        // Validity is judged once, on the first cycle a digit is presented.
        if ((cnt_q == '0) && (digit > 4'd9)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == LAST_CNT) begin
          result_d[{idx_q, 2'b00} +: 4] = conv;
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_busy   = (state_q != S_IDLE);
  assign bus.out_done   = (state_q == S_DONE);
  assign bus.out_err    = err_q;
  assign bus.out_result = result_q;
  assign {out_A, out_B, out_C, out_D} = drive;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb/tb_bcd_seq_ctrl.sv - directed bench for bcd_seq_ctrl with an excess-3 converter stub
module tb_bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_seq_ctrl_if #(.NDIG(4)) if1 ();
  bcd_seq_ctrl_if #(.NDIG(4)) if3 ();

  logic a1, b1, c1, d1, w1, x1, y1, z1;
  logic a3, b3, c3, d3, w3, x3, y3, z3;

  assign {w1, x1, y1, z1} = {a1, b1, c1, d1} + 4'd3;
  assign {w3, x3, y3, z3} = {a3, b3, c3, d3} + 4'd3;

  bcd_seq_ctrl #(.NDIG(4), .SETTLE(1)) u1 (
    .in_clk(clk), .in_rst(rst), .bus(if1.slave),
    .out_A(a1), .out_B(b1), .out_C(c1), .out_D(d1),
    .in_W(w1), .in_X(x1), .in_Y(y1), .in_Z(z1)
  );

  bcd_seq_ctrl #(.NDIG(4), .SETTLE(3)) u3 (
    .in_clk(clk), .in_rst(rst), .bus(if3.slave),
    .out_A(a3), .out_B(b3), .out_C(c3), .out_D(d3),
    .in_W(w3), .in_X(x3), .in_Y(y3), .in_Z(z3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.in_start = 1'b1; if1.in_data = 16'h9210;
    if3.in_start = 1'b1; if3.in_data = 16'h0007;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({if1.out_busy, if1.out_done, if1.out_err} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags: got %b expected 000", {if1.out_busy, if1.out_done, if1.out_err});
      end
      n_checks++;
      if (if1.out_result !== 16'h0000) begin
        n_fail++; $display("FAIL reset_result: got %h expected 0000", if1.out_result);
      end
      n_checks++;
      if ({a1, b1, c1, d1} !== 4'h0) begin
        n_fail++; $display("FAIL reset_digit: got %h expected 0", {a1, b1, c1, d1});
      end
      n_checks++;
      if (if3.out_busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy3: got %b expected 0", if3.out_busy);
      end
    end
    rst = 1'b0;
    if1.in_start = 1'b0;
    if3.in_start = 1'b0;
    step();
    n_checks++;
    if ({if1.out_busy, if3.out_busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 00", {if1.out_busy, if3.out_busy});
    end
  endtask

  task automatic test_settle1();
    logic [15:0] w;
    w = 16'h9210;
    if1.in_data = w; if1.in_start = 1'b1;
    step();
    if1.in_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if ({a1, b1, c1, d1} !== w[4*(c-1) +: 4]) begin
        n_fail++; $display("FAIL s1_digit cycle %0d: got %h expected %h", c, {a1, b1, c1, d1}, w[4*(c-1) +: 4]);
      end
      n_checks++;
      if ({if1.out_busy, if1.out_done} !== 2'b10) begin
        n_fail++; $display("FAIL s1_busy_done cycle %0d: got %b expected 10", c, {if1.out_busy, if1.out_done});
      end
      step();
    end
    n_checks++;
    if ({if1.out_busy, if1.out_done, if1.out_err} !== 3'b110) begin
      n_fail++; $display("FAIL s1_done_flags: got %b expected 110", {if1.out_busy, if1.out_done, if1.out_err});
    end
    n_checks++;
    if (if1.out_result !== 16'hC543) begin
      n_fail++; $display("FAIL s1_result: got %h expected C543", if1.out_result);
    end
    step();
    n_checks++;
    if ({if1.out_busy, if1.out_done} !== 2'b00 || if1.out_result !== 16'hC543) begin
      n_fail++; $display("FAIL s1_after_done: got busy/done %b result %h expected 00 C543", {if1.out_busy, if1.out_done}, if1.out_result);
    end
  endtask

  task automatic test_settle3();
    logic [15:0] w;
    w = 16'h0007;
    if3.in_data = w; if3.in_start = 1'b1;
    step();
    if3.in_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_checks++;
      if ({a3, b3, c3, d3} !== w[4*((c-1)/3) +: 4] || {if3.out_busy, if3.out_done} !== 2'b10) begin
        n_fail++; $display("FAIL s3_drive cycle %0d: got digit %h busy/done %b expected %h 10", c, {a3, b3, c3, d3}, {if3.out_busy, if3.out_done}, w[4*((c-1)/3) +: 4]);
      end
      step();
    end
    n_checks++;
    if (if3.out_done !== 1'b1 || if3.out_result !== 16'h333A || if3.out_err !== 1'b0) begin
      n_fail++; $display("FAIL s3_done: got done %b result %h err %b expected 1 333A 0", if3.out_done, if3.out_result, if3.out_err);
    end
    step();
    n_checks++;
    if (if3.out_busy !== 1'b0) begin
      n_fail++; $display("FAIL s3_idle: got busy %b expected 0", if3.out_busy);
    end
  endtask

  task automatic test_abort_back_to_back();
    logic [15:0] w;
    w = 16'h3B21;
    if1.in_data = w; if1.in_start = 1'b1;
    step();
    if1.in_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if ({a1, b1, c1, d1} !== w[4*(c-1) +: 4] || {if1.out_done, if1.out_err} !== 2'b00) begin
        n_fail++; $display("FAIL abort_drive cycle %0d: got digit %h done/err %b expected %h 00", c, {a1, b1, c1, d1}, {if1.out_done, if1.out_err}, w[4*(c-1) +: 4]);
      end
      step();
    end
    n_checks++;
    if ({if1.out_busy, if1.out_done, if1.out_err} !== 3'b111 || if1.out_result !== 16'h0054) begin
      n_fail++; $display("FAIL abort_done: got flags %b result %h expected 111 0054", {if1.out_busy, if1.out_done, if1.out_err}, if1.out_result);
    end
    n_checks++;
    if ({a1, b1, c1, d1} !== 4'h0) begin
      n_fail++; $display("FAIL abort_done_digit: got %h expected 0", {a1, b1, c1, d1});
    end
    step();
    n_checks++;
    if ({if1.out_busy, if1.out_err} !== 2'b01 || if1.out_result !== 16'h0054) begin
      n_fail++; $display("FAIL abort_hold: got busy/err %b result %h expected 01 0054", {if1.out_busy, if1.out_err}, if1.out_result);
    end
    if1.in_data = 16'h0000; if1.in_start = 1'b1;
    step();
    if1.in_start = 1'b0;
    n_checks++;
    if ({if1.out_busy, if1.out_err} !== 2'b10 || if1.out_result !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_accept: got busy/err %b result %h expected 10 0000", {if1.out_busy, if1.out_err}, if1.out_result);
    end
    repeat (4) step();
    n_checks++;
    if ({if1.out_done, if1.out_err} !== 2'b10 || if1.out_result !== 16'h3333) begin
      n_fail++; $display("FAIL b2b_done: got done/err %b result %h expected 10 3333", {if1.out_done, if1.out_err}, if1.out_result);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    if1.in_data = 16'h1111; if1.in_start = 1'b1;
    step();
    if1.in_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (if1.out_done === 1'b1) ndone++;
      if (c == 5) begin
        n_checks++;
        if (if1.out_done !== 1'b1 || if1.out_result !== 16'h4444) begin
          n_fail++; $display("FAIL ignore_done: got done %b result %h expected 1 4444", if1.out_done, if1.out_result);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (if1.out_busy !== 1'b0) begin
          n_fail++; $display("FAIL ignore_no_queue: got busy %b expected 0", if1.out_busy);
        end
      end
      if (c == 2) if1.in_data = 16'h9999;
      if1.in_start = (c == 2 || c == 5);
      step();
    end
    n_checks++;
    if (ndone !== 1 || if1.out_busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_single_done: got %0d pulses busy %b expected 1 0", ndone, if1.out_busy);
    end
  endtask

  task automatic test_reset_midrun();
    int ndone;
    ndone = 0;
    if1.in_data = 16'h5678; if1.in_start = 1'b1;
    step();
    if1.in_start = 1'b0;
    step();
    step();
    n_checks++;
    if (if1.out_busy !== 1'b1 || if1.out_result !== 16'h00AB) begin
      n_fail++; $display("FAIL midrun_partial: got busy %b result %h expected 1 00AB", if1.out_busy, if1.out_result);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({if1.out_busy, if1.out_done, if1.out_err} !== 3'b000 || if1.out_result !== 16'h0000 || {a1, b1, c1, d1} !== 4'h0) begin
      n_fail++; $display("FAIL midrun_reset: got flags %b result %h digit %h expected 000 0000 0", {if1.out_busy, if1.out_done, if1.out_err}, if1.out_result, {a1, b1, c1, d1});
    end
    for (int c = 0; c < 6; c++) begin
      if (if1.out_done === 1'b1 || if1.out_busy === 1'b1) ndone++;
      step();
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL midrun_quiet: got %0d active cycles expected 0", ndone);
    end
  endtask

  initial begin
    rst = 1'b1;
    if1.in_start = 1'b0; if1.in_data = '0;
    if3.in_start = 1'b0; if3.in_data = '0;
    test_reset();
    test_settle1();
    test_settle3();
    test_abort_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
